// File: rtl/audio_sample_fifo_if.sv
// Sample FIFO bus: mixer write side, register-mux read side, status.
// Optional low-water threshold/flag ports exist with AUDIO_FIFO_LOW_WATER_EN.
interface audio_sample_fifo_if #(
    parameter int FIFO_WIDTH    = 6,
    parameter int AUD_BIT_DEPTH = 24
);
    logic                     wr_en;
    logic [AUD_BIT_DEPTH-1:0] lsample_in;
    logic [AUD_BIT_DEPTH-1:0] rsample_in;
    logic                     l_read;
    logic                     r_read;
    logic                     clear_flags;
    logic [AUD_BIT_DEPTH-1:0] lsound_out;
    logic [AUD_BIT_DEPTH-1:0] rsound_out;
    logic [FIFO_WIDTH:0]      level;
    logic                     empty;
    logic                     full;
    logic                     overflow;
    logic                     underflow;
`ifdef AUDIO_FIFO_LOW_WATER_EN
    logic [FIFO_WIDTH:0]      low_water_thr;
    logic                     low_water;
`endif

    modport master (
        output wr_en, lsample_in, rsample_in,
        output l_read, r_read, clear_flags,
`ifdef AUDIO_FIFO_LOW_WATER_EN
        output low_water_thr,
        input  low_water,
`endif
        input  lsound_out, rsound_out,
        input  level, empty, full,
        input  overflow, underflow
    );

    modport slave (
        input  wr_en, lsample_in, rsample_in,
        input  l_read, r_read, clear_flags,
`ifdef AUDIO_FIFO_LOW_WATER_EN
        input  low_water_thr,
        output low_water,
`endif
        output lsound_out, rsound_out,
        output level, empty, full,
        output overflow, underflow
    );
endinterface

// File: rtl/audio_sample_fifo.sv
// Stereo show-ahead frame FIFO between mixer and CPU audio register mux.
// Ports: clk, reset (async high), bus (slave modport of audio_sample_fifo_if):
//   wr_en/lsample_in/rsample_in push a frame; l_read peeks, r_read pops;
//   lsound_out/rsound_out show the head frame (0 when empty);
//   level/empty/full registered; overflow/underflow sticky until clear_flags.
// Optional feature macro AUDIO_FIFO_LOW_WATER_EN adds low_water_thr/low_water.
module audio_sample_fifo #(
    parameter int FIFO_WIDTH    = 6,
    parameter int AUD_BIT_DEPTH = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    audio_sample_fifo_if.slave    bus
);
    localparam int DEPTH = 1 << FIFO_WIDTH;
    localparam int FRAME = 2 * AUD_BIT_DEPTH;

    logic [FRAME-1:0]    mem [DEPTH];
    logic [FIFO_WIDTH:0] wr_ptr;
    logic [FIFO_WIDTH:0] rd_ptr;
    logic [FIFO_WIDTH:0] level_q;
    logic [FIFO_WIDTH:0] level_next;
    logic                empty_q;
    logic                full_q;
    logic                ovf_q;
    logic                unf_q;
    logic                do_pop;
    logic                do_push;
    logic                ovf_evt;
    logic                unf_evt;
    logic [FRAME-1:0]    head;

    // A pop in the same cycle frees the slot, so a write to a full
    // FIFO is accepted whenever r_read pops alongside it.
    always_comb begin
        do_pop     = bus.r_read && !empty_q;
        do_push    = bus.wr_en && (!full_q || do_pop);
        ovf_evt    = bus.wr_en && !do_push;
        unf_evt    = bus.r_read && empty_q;
        level_next = level_q
                   + (FIFO_WIDTH+1)'(do_push)
                   - (FIFO_WIDTH+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[FIFO_WIDTH-1:0]] <= {bus.lsample_in, bus.rsample_in};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level_q <= level_next;
            empty_q <= (level_next == '0);
            full_q  <= (level_next == (FIFO_WIDTH+1)'(DEPTH));
        end
    end

    // New error events take priority over a coincident clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_evt)              ovf_q <= 1'b1;
            else if (bus.clear_flags) ovf_q <= 1'b0;
            if (unf_evt)              unf_q <= 1'b1;
            else if (bus.clear_flags) unf_q <= 1'b0;
        end
    end

`ifdef AUDIO_FIFO_LOW_WATER_EN
    logic low_water_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            low_water_q <= 1'b1;
        end else begin
            low_water_q <= (level_next <= bus.low_water_thr);
        end
    end

    assign bus.low_water = low_water_q;
`endif

    // Array contents are not reset, so mask the head while empty.
    assign head           = mem[rd_ptr[FIFO_WIDTH-1:0]];
    assign bus.lsound_out = empty_q ? '0 : head[FRAME-1:AUD_BIT_DEPTH];
    assign bus.rsound_out = empty_q ? '0 : head[AUD_BIT_DEPTH-1:0];
    assign bus.level      = level_q;
    assign bus.empty      = empty_q;
    assign bus.full       = full_q;
    assign bus.overflow   = ovf_q;
    assign bus.underflow  = unf_q;
endmodule

// File: doc/audio_sample_fifo.md
Name: audio_sample_fifo

Overview:
- Stereo sample FIFO that buffers synth-engine output frames (left/right pairs) between the voice/mixer pipeline and the CPU-facing audio register mux.
- Written once per generated frame by the mixer strobe.
- Drained by the mux's l_read/r_read strobes; presents the head frame on lsound_out/rsound_out for the mux to latch.
- Reports fill level and sticky overflow/underflow so the host-side (JACK) loop can size its buffer.

Parameters:
FIFO_WIDTH, 6, log2 of depth in frames; depth = 2^FIFO_WIDTH = 64 frames
AUD_BIT_DEPTH, 24, bits per channel sample

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
wr_en  input  1  one-cycle strobe: push {lsample_in, rsample_in} as one frame
lsample_in  input  AUD_BIT_DEPTH  left sample from mixer
rsample_in  input  AUD_BIT_DEPTH  right sample from mixer
l_read  input  1  mux reading left channel of head frame (no pop)
r_read  input  1  mux reading right channel of head frame (pops frame)
clear_flags  input  1  one-cycle strobe: clear sticky overflow/underflow
lsound_out  output  AUD_BIT_DEPTH  left sample of head frame
rsound_out  output  AUD_BIT_DEPTH  right sample of head frame
level  output  FIFO_WIDTH+1  frames currently stored, 0..2^FIFO_WIDTH
empty  output  1  level == 0
full  output  1  level == 2^FIFO_WIDTH
overflow  output  1  sticky: a write was dropped
underflow  output  1  sticky: a pop was attempted while empty

Behaviour:
- Storage: 2^FIFO_WIDTH x (2*AUD_BIT_DEPTH) array. wr_ptr and rd_ptr are FIFO_WIDTH+1 bits; the MSB distinguishes full from empty. The pointers wrap naturally.
- Reset (async, while reset high):
  - wr_ptr, rd_ptr = 0; level = 0; empty = 1; full = 0; overflow = 0; underflow = 0.
  - Outputs = 0. Array contents are don't-care.
  - Reset mid-operation discards all stored frames. No partial frame survives.
- Head presentation: show-ahead.
  - lsound_out/rsound_out = array[rd_ptr] combinationally, valid in the same cycle as l_read/r_read. The mux latches on that edge.
  - Both outputs are forced to 0 while empty.
- Push: wr_en && !full -> write the frame at wr_ptr, wr_ptr+1. The data is visible at head on the next cycle if the FIFO was empty (zero-bubble, 1-cycle latency).
- Pop: r_read && !empty -> rd_ptr+1 at the clock edge. l_read never pops.
- Simultaneous wr_en && r_read:
  - Not empty: both act; level unchanged.
  - Full: pop and push both act (no overflow); level stays full.
  - Empty: push acts, pop is ignored and underflow is set.
- Overflow: wr_en while full and no accompanying pop -> frame dropped, overflow <= 1.
- Underflow: r_read while empty -> ignored, underflow <= 1.
- Sticky flags: hold until clear_flags. If clear_flags coincides with a new error event, the event wins (flag stays 1).
- l_read and r_read asserted together: treat as r_read (pop once).
- level, empty, full: registered from the pointers; they update on the edge following a push/pop, same cycle as the pointers.
- Single clock domain; no CDC inside. wr_en is already synchronous to clk.

Optional Feature:
- Macro: AUDIO_FIFO_LOW_WATER_EN
- Defined: adds ports low_water_thr (input, FIFO_WIDTH+1) and low_water (output, 1).
  - low_water is registered: low_water <= (level_next <= low_water_thr). It is therefore valid the same cycle as level.
  - Reset value is 1.
  - Intended to kick the mixer run trigger when the buffer drains.
- Undefined: neither port exists; no extra logic.

Test Plan:
- Reset then idle -> level=0, empty=1, full=0, lsound_out=rsound_out=0, flags 0.
- Push 3 frames (L=0x000001..3, R=0x100001..3); then issue l_read/r_read pairs 2 cycles apart -> head reads L1/R1, L2/R2, L3/R3 in order; level steps 3,2,1,0; empty=1 at end.
- Push 64 frames -> full=1, level=64; 65th wr_en -> dropped, overflow=1, level stays 64; clear_flags -> overflow=0.
- Full FIFO, wr_en and r_read in the same cycle -> no overflow, level=64, head advances by one frame, new frame appears last; the wrap past pointer 63 reads back correctly.
- Empty FIFO, r_read -> underflow=1, pointers unchanged. Then wr_en+r_read together on empty -> frame stored, level=1, underflow stays 1.
- With AUDIO_FIFO_LOW_WATER_EN and thr=4: fill to 6 -> low_water=0; drain to 4 -> low_water=1 on the same cycle as level=4. Assert reset mid-fill -> level=0, low_water=1.
